// File: rtl/peri_serial_rx_if.sv
// Bus between a serial peripheral link and its word consumer.
//   s_clk, s_data, s_cs_n : raw serial lines from the peripheral (asynchronous)
//   rx_ready, clear_err   : consumer acknowledge and sticky-flag clear
//   rx_data, rx_valid     : received word and its pending flag
//   busy, overrun,
//   frame_err             : receiver status
// The receiver connects through the slave modport; the consumer/driver
// side uses master.
`timescale 1ns/1ps
interface peri_serial_rx_if #(
  parameter int WIDTH = 16
);
  logic             s_clk;
  logic             s_data;
  logic             s_cs_n;
  logic             rx_ready;
  logic             clear_err;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             busy;
  logic             overrun;
  logic             frame_err;

  modport slave (
    input  s_clk, s_data, s_cs_n, rx_ready, clear_err,
    output rx_data, rx_valid, busy, overrun, frame_err
  );

  modport master (
    output s_clk, s_data, s_cs_n, rx_ready, clear_err,
    input  rx_data, rx_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/peri_serial_rx.sv
// Serial word receiver. Oversamples an asynchronous clocked serial link
// (s_clk / s_data / s_cs_n), assembles WIDTH-bit words and hands them to a
// consumer with a valid/ready style acknowledge. Dropped words and
// truncated frames raise sticky flags.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-low
//   bus   : peri_serial_rx_if.slave (serial lines, consumer handshake, status)
`timescale 1ns/1ps
module peri_serial_rx #(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic           clock,
  input  logic           reset,
  peri_serial_rx_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, SHIFT = 2'd2} state_t;

  logic             sclk_s1_q, sclk_s2_q, sclk_prev_q;
  logic             sdat_s1_q, sdat_s2_q;
  logic             cs_s1_q, cs_s2_q;
  logic [1:0]       settle_q;
  logic             edge_p0_q, bit_p0_q, cs_p0_q;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_p1_q;
  logic             done_p1_q;
  logic [WIDTH-1:0] rx_data_q;
  logic             rx_valid_q, overrun_q, frame_err_q;
  logic             word_done, ferr_set, ovr_set;

  // Synchronizers and edge detect; p0 aligns edge, data bit and select so
  // a bit and a select deassertion seen together are handled in one cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sclk_s1_q   <= 1'b0;
      sclk_s2_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      sdat_s1_q   <= 1'b0;
      sdat_s2_q   <= 1'b0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      settle_q    <= 2'd0;
      edge_p0_q   <= 1'b0;
      bit_p0_q    <= 1'b0;
      cs_p0_q     <= 1'b1;
    end else begin
      sclk_s1_q   <= bus.s_clk;
      sclk_s2_q   <= sclk_s1_q;
      sclk_prev_q <= sclk_s2_q;
      sdat_s1_q   <= bus.s_data;
      sdat_s2_q   <= sdat_s1_q;
      cs_s1_q     <= bus.s_cs_n;
      cs_s2_q     <= cs_s1_q;
      // Counts until the select pipeline holds a real pin sample rather
      // than its reset value of 1.
      settle_q    <= (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
      edge_p0_q   <= sclk_s2_q & ~sclk_prev_q;
      bit_p0_q    <= sdat_s2_q;
      cs_p0_q     <= cs_s2_q;
    end
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (state_q == SHIFT && edge_p0_q) begin
      shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], bit_p0_q}
                                 : {bit_p0_q, shift_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
    end
    word_done = (state_q == SHIFT) && (cnt_d == CNT_W'(WIDTH));
    // The bit on the same cycle as the select rise is counted first.
    ferr_set  = (state_q == SHIFT) && cs_p0_q && !word_done && (cnt_d != '0);
    ovr_set   = done_p1_q && rx_valid_q && !bus.rx_ready;
  end

  // Frame FSM; p1 carries a completed word to the output stage.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      word_p1_q <= '0;
      done_p1_q <= 1'b0;
    end else begin
      done_p1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Without the settle wait, the reset value of the select
          // pipeline would arm the receiver in the middle of a frame.
          if (settle_q == 2'd3 && cs_p0_q) state_q <= ARMED;
        end
        ARMED: begin
          if (!cs_p0_q) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
            shift_q <= '0;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          cnt_q   <= word_done ? '0 : cnt_d;
          if (word_done) begin
            done_p1_q <= 1'b1;
            word_p1_q <= shift_d;
          end
          if (cs_p0_q) state_q <= ARMED;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output stage: accept, hold or drop the completed word.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (done_p1_q) begin
        if (!rx_valid_q || bus.rx_ready) begin
          rx_data_q  <= word_p1_q;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      // A set in the same cycle as clear_err wins.
      if (ovr_set)            overrun_q <= 1'b1;
      else if (bus.clear_err) overrun_q <= 1'b0;
      if (ferr_set)           frame_err_q <= 1'b1;
      else if (bus.clear_err) frame_err_q <= 1'b0;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.busy      = (state_q == SHIFT);
  assign bus.overrun   = overrun_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_peri_serial_rx.sv
`timescale 1ns/1ps
module tb_peri_serial_rx;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic s_clk = 1'b0, s_data = 1'b0, s_cs_n = 1'b1;
  logic rx_ready = 1'b0, clear_err = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] q_m[$];
  logic [15:0] q_l[$];
  logic        vm_prev = 1'b0;
  logic        vl_prev = 1'b0;

  always #5 clock = ~clock;

  peri_serial_rx_if #(.WIDTH(16)) bus_m ();
  peri_serial_rx_if #(.WIDTH(16)) bus_l ();

  assign bus_m.s_clk = s_clk;      assign bus_l.s_clk = s_clk;
  assign bus_m.s_data = s_data;    assign bus_l.s_data = s_data;
  assign bus_m.s_cs_n = s_cs_n;    assign bus_l.s_cs_n = s_cs_n;
  assign bus_m.rx_ready = rx_ready; assign bus_l.rx_ready = rx_ready;
  assign bus_m.clear_err = clear_err; assign bus_l.clear_err = clear_err;

  peri_serial_rx #(.WIDTH(16), .MSB_FIRST(1)) dut_m (
    .clock(clock), .reset(reset), .bus(bus_m)
  );
  peri_serial_rx #(.WIDTH(16), .MSB_FIRST(0)) dut_l (
    .clock(clock), .reset(reset), .bus(bus_l)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rev16(input logic [15:0] w);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = w[15-i];
    return r;
  endfunction

  // Scoreboard monitors: a new word is announced by a rising rx_valid.
  always @(negedge clock) begin
    logic [15:0] e;
    if (bus_m.rx_valid === 1'b1 && vm_prev === 1'b0) begin
      if (q_m.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL msb unexpected word: got 0x%0h, expected none", bus_m.rx_data);
      end else begin
        e = q_m.pop_front();
        chk("msb word", {16'h0, bus_m.rx_data}, {16'h0, e});
      end
    end
    vm_prev = bus_m.rx_valid;
  end

  always @(negedge clock) begin
    logic [15:0] e;
    if (bus_l.rx_valid === 1'b1 && vl_prev === 1'b0) begin
      if (q_l.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL lsb unexpected word: got 0x%0h, expected none", bus_l.rx_data);
      end else begin
        e = q_l.pop_front();
        chk("lsb word", {16'h0, bus_l.rx_data}, {16'h0, e});
      end
    end
    vl_prev = bus_l.rx_valid;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_word(input logic [15:0] w);
    q_m.push_back(w);
    q_l.push_back(rev16(w));
  endtask

  task automatic send_bit(input logic b, input bit lat_check);
    int lat;
    s_data = b;
    cyc(4);
    s_clk = 1'b1;
    if (lat_check) begin
      lat = 0;
      while (bus_m.rx_valid !== 1'b1 && lat < 10) begin
        @(negedge clock);
        lat++;
      end
      chk("latency", lat, 5);
      cyc(1);
    end else begin
      cyc(4);
    end
    s_clk = 1'b0;
  endtask

  // Sends the top n_bits of w, bit 15 first on the wire.
  task automatic send_word(input logic [15:0] w, input int n_bits, input bit lat_last);
    for (int i = 0; i < n_bits; i++)
      send_bit(w[15-i], lat_last && (i == n_bits - 1));
  endtask

  task automatic frame_start();
    s_cs_n = 1'b0;
    cyc(6);
  endtask

  task automatic frame_end();
    cyc(4);
    s_cs_n = 1'b1;
    cyc(10);
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    cyc(1);
    clear_err = 1'b0;
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset = 1'b0;
    cyc(4);
    chk("reset rx_data",   {16'h0, bus_m.rx_data}, 32'h0);
    chk("reset rx_valid",  bus_m.rx_valid, 0);
    chk("reset busy",      bus_m.busy, 0);
    chk("reset overrun",   bus_m.overrun, 0);
    chk("reset frame_err", bus_m.frame_err, 0);
    reset = 1'b1;
    cyc(10);

    // Single word 0xA5C3, with latency on the final bit
    expect_word(16'hA5C3);
    frame_start();
    chk("busy in frame", bus_m.busy, 1);
    send_word(16'hA5C3, 16, 1'b1);
    frame_end();
    chk("t1 rx_data",   {16'h0, bus_m.rx_data}, 32'hA5C3);
    chk("t1 rx_valid",  bus_m.rx_valid, 1);
    chk("t1 overrun",   bus_m.overrun, 0);
    chk("t1 frame_err", bus_m.frame_err, 0);
    chk("t1 busy",      bus_m.busy, 0);
    consume();
    chk("t1 consumed",  bus_m.rx_valid, 0);

    // Two words back to back, consumer always ready
    rx_ready = 1'b1;
    expect_word(16'h1234);
    expect_word(16'hBEEF);
    frame_start();
    send_word(16'h1234, 16, 1'b0);
    send_word(16'hBEEF, 16, 1'b0);
    frame_end();
    chk("t2 rx_data",  {16'h0, bus_m.rx_data}, 32'hBEEF);
    chk("t2 rx_valid", bus_m.rx_valid, 0);
    rx_ready = 1'b0;

    // Overrun: second word dropped while first is pending
    expect_word(16'h1111);
    frame_start();
    send_word(16'h1111, 16, 1'b0);
    send_word(16'h2222, 16, 1'b0);
    frame_end();
    chk("t3 rx_data",  {16'h0, bus_m.rx_data}, 32'h1111);
    chk("t3 overrun",  bus_m.overrun, 1);
    pulse_clear();
    chk("t3 overrun cleared", bus_m.overrun, 0);
    chk("t3 rx_valid held",   bus_m.rx_valid, 1);
    consume();

    // Truncated frame after 5 bits
    frame_start();
    send_word(16'hF800, 5, 1'b0);
    frame_end();
    chk("t4 frame_err", bus_m.frame_err, 1);
    chk("t4 rx_valid",  bus_m.rx_valid, 0);
    expect_word(16'h00FF);
    frame_start();
    send_word(16'h00FF, 16, 1'b0);
    frame_end();
    chk("t4 rx_data", {16'h0, bus_m.rx_data}, 32'h00FF);
    consume();
    pulse_clear();
    chk("t4 frame_err cleared", bus_m.frame_err, 0);

    // Reset mid-frame; remaining bits must not form a word
    frame_start();
    send_word(16'hFF00, 8, 1'b0);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk("t5 busy after reset", bus_m.busy, 0);
    send_word(16'h00FF, 8, 1'b0);
    cyc(4);
    chk("t5 no word", bus_m.rx_valid, 0);
    frame_end();
    expect_word(16'h5A5A);
    frame_start();
    send_word(16'h5A5A, 16, 1'b0);
    frame_end();
    chk("t5 rx_data", {16'h0, bus_m.rx_data}, 32'h5A5A);
    consume();

    // Bit order: 1,0,0,0 then zeros; LSB-first receiver sees 0x0001
    expect_word(16'h8000);
    frame_start();
    send_word(16'h8000, 16, 1'b0);
    frame_end();
    chk("t6 lsb rx_data", {16'h0, bus_l.rx_data}, 32'h0001);
    chk("t6 msb rx_data", {16'h0, bus_m.rx_data}, 32'h8000);
    consume();

    cyc(10);
    chk("msb queue drained", q_m.size(), 0);
    chk("lsb queue drained", q_l.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/peri_serial_rx.md
PERI_SERIAL_RX -- requirements
Module: peri_serial_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the number of bits per received word.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = first serial bit lands in rx_data[WIDTH-1], 0 = first bit lands in rx_data[0].
REQ-003 clock  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 s_clk  input  1  serial clock from the peripheral bus, asynchronous to clock.
REQ-006 s_data  input  1  serial data, asynchronous to clock.
REQ-007 s_cs_n  input  1  frame select, active-low, asynchronous to clock.
REQ-008 rx_ready  input  1  consumer acknowledge for rx_data.
REQ-009 clear_err  input  1  one-cycle clear for the overrun and frame_err flags.
REQ-010 rx_data  output  WIDTH  last accepted word.
REQ-011 rx_valid  output  1  rx_data holds an unacknowledged word.
REQ-012 busy  output  1  frame in progress (state SHIFT).
REQ-013 overrun  output  1  sticky: a completed word was dropped.
REQ-014 frame_err  output  1  sticky: frame ended with a partial word.

Function
REQ-015 s_clk, s_data and s_cs_n SHALL each pass through a 2-flop synchronizer; the synchronizer reset values SHALL be 0, 0 and 1.
REQ-016 A serial rising edge SHALL be detected when synced s_clk is 1 and its registered copy is 0.
REQ-017 Serial timing SHALL be: s_clk high and low phases each at least 3 clock cycles; s_data stable at least 3 cycles around each s_clk rise.
REQ-018 States SHALL be IDLE, ARMED and SHIFT.
REQ-019 IDLE -> ARMED when synced s_cs_n = 1.
REQ-020 ARMED -> SHIFT when synced s_cs_n = 0; the bit counter and shift register SHALL be cleared on this transition.
REQ-021 In SHIFT, each detected s_clk rise SHALL shift in synced s_data (per MSB_FIRST) and increment the bit counter.
REQ-022 When the counter reaches WIDTH, the word SHALL complete in the same cycle: the counter wraps to 0 and the state stays SHIFT, so further edges in the same frame start the next word.
REQ-023 On word completion with rx_valid = 0, or with rx_valid = 1 and rx_ready = 1 in the same cycle: rx_data <= word and rx_valid = 1 from the next cycle.
REQ-024 On word completion with rx_valid = 1 and rx_ready = 0: the new word SHALL be discarded, rx_data unchanged, overrun <= 1.
REQ-025 rx_ready = 1 with rx_valid = 1 and no completion SHALL clear rx_valid on the next cycle; rx_ready with rx_valid = 0 has no effect.
REQ-026 SHIFT -> ARMED when synced s_cs_n = 1; if the counter is nonzero, the partial word SHALL be discarded and frame_err <= 1.
REQ-027 If an s_clk rise and s_cs_n deassertion are detected in the same cycle, the bit SHALL be taken first, and the completion/error check SHALL use the updated counter.
REQ-028 clear_err = 1 SHALL clear overrun and frame_err; a set event in the same cycle SHALL win.
REQ-029 busy SHALL equal (state == SHIFT).
REQ-030 Latency: rx_valid SHALL rise exactly 4 clock cycles after the clock edge that first samples the final s_clk rise into the synchronizer.

Reset
REQ-031 With reset = 0 at a clock edge: state = IDLE, synchronizers to REQ-015 values, counter = 0, shift register = 0, rx_data = 0, rx_valid = 0, busy = 0, overrun = 0, frame_err = 0.
REQ-032 Reset mid-frame SHALL abandon the frame; no word is accepted until s_cs_n is seen high and then low again (IDLE -> ARMED -> SHIFT).

Verification
REQ-033 WIDTH = 16, MSB_FIRST = 1, send 0xA5C3 in one frame -> rx_data = 0xA5C3, rx_valid = 1, overrun = 0, frame_err = 0, busy = 0 after s_cs_n rises.
REQ-034 Two words 0x1234 and 0xBEEF in one frame, rx_ready held 1 -> two rx_valid events with rx_data 0x1234 then 0xBEEF.
REQ-035 Two words 0x1111 and 0x2222, rx_ready held 0 -> rx_data = 0x1111, overrun = 1; pulse clear_err -> overrun = 0.
REQ-036 s_cs_n rises after 5 bits -> frame_err = 1, rx_valid unchanged; next full frame with 0x00FF -> rx_data = 0x00FF.
REQ-037 Reset pulsed after 8 bits while s_cs_n stays low, then 8 more bits -> no rx_valid; s_cs_n high then low, then 16 bits of 0x5A5A -> rx_data = 0x5A5A.
REQ-038 MSB_FIRST = 0, send bit sequence 1,0,0,0 then 12 zeros -> rx_data = 0x0001.
